branch_predictor: RTL and testbench
===================================

# branch_predictor

- Supplies the `take_flag` prediction consumed by the instruction scheduler for the instruction word returning from CRAM in the same cycle.
- Uses a gshare pattern table of 2-bit saturating counters, indexed by fetch PC XOR global history.
- Learns from branch resolutions reported by the core's branch unit.
- Sits beside fetch: reads the scheduler's fetch address, writes the scheduler's `take_flag` input.

## Interface
Parameters:
- `IDX_W`, 8, table index width; table has 2**IDX_W entries.
- `GHR_W`, 8, global history length; must be <= IDX_W.
- `INIT_CNT`, 2'b01, counter value written by the init sweep (weakly not-taken).

Ports:
- `clk` in 1, the block's single clock.
- `rst` in 1, asynchronous, active-high reset.
- `i_fetch_pc` in CRAM_ADDR_W, address of the instruction word currently on CRAM rdata.
- `take_flag` out 1, prediction for `i_fetch_pc`; combinational from table and GHR.
- `i_resolve_valid` in 1, one conditional branch resolved this cycle.
- `i_resolve_pc` in CRAM_ADDR_W, address of the resolved branch.
- `i_resolve_taken` in 1, actual outcome of the resolved branch.
- `i_resolve_mispred` in 1, prediction was wrong; qualified by `i_resolve_valid`.
- `o_busy` out 1, init sweep in progress.
- `o_branch_cnt` out 32, resolved branches counted since reset.
- `o_miss_cnt` out 32, mispredictions counted since reset.

## Operation
- Index function: idx(pc) = pc[IDX_W+1:2] XOR zero-extended GHR. PC bits [1:0] are ignored because fetch is word-aligned with a step of 4.
- Table: 2**IDX_W entries of 2-bit counters; asynchronous read, one synchronous write port.
- FSM states:
  - INIT: on `rst`, go to INIT with `init_ptr`=0, GHR=0, both statistics counters=0. Each cycle write INIT_CNT to entry `init_ptr`, then increment it. When `init_ptr` = 2**IDX_W-1 has been written, go to RUN. In INIT, `o_busy`=1, `take_flag`=0, and resolve inputs are ignored entirely (no table, GHR or counter change).
  - RUN: `o_busy`=0. `take_flag` = table[idx(i_fetch_pc)][1].
    - On `i_resolve_valid`: index with idx(i_resolve_pc) using the pre-update GHR.
    - Counter increments (saturates at 3) if taken, decrements (saturates at 0) if not.
    - GHR <= {GHR[GHR_W-2:0], i_resolve_taken}.
    - `o_branch_cnt`+1; `o_miss_cnt`+1 if `i_resolve_mispred`.
    - Both statistics counters saturate at 32'hFFFF_FFFF and do not wrap.
- GHR is non-speculative: it changes only on resolution, never on prediction.
- Simultaneous fetch and resolve to the same index: the prediction uses the pre-write counter value; the new value is visible from the next cycle.
- `i_resolve_mispred` without `i_resolve_valid` is ignored.
- Reset asserted mid-INIT or mid-RUN restarts INIT from entry 0. All table contents are rewritten by the sweep; none are relied upon.

## Timing
- Reset values: `take_flag`=0, `o_busy`=1, `o_branch_cnt`=0, `o_miss_cnt`=0. GHR=0, `init_ptr`=0, state=INIT.
- INIT lasts exactly 2**IDX_W cycles after `rst` deasserts. `o_busy` falls at the edge after entry 2**IDX_W-1 is written (256 cycles with defaults).
- Prediction latency: 0 cycles, combinational from `i_fetch_pc` and state.
- Update latency: a resolve at edge N affects predictions from cycle N+1.
- No backpressure: at most one resolve per cycle, always accepted in RUN.

## Test plan
- Reset and init: deassert `rst`, hold `i_resolve_valid`=1 throughout.
  - `o_busy`=1 and `take_flag`=0 for 256 cycles, then `o_busy`=0.
  - `o_branch_cnt`=0 at the end of INIT.
  - Any PC then predicts 0.
- Training: resolve pc=0x40 taken twice, with GHR handled accordingly.
  - Counter goes 01->10->11.
  - Fetch of 0x40 under the matching GHR gives `take_flag`=1.
  - Two not-taken resolves return it to 01, predicting 0.
- Saturation: five taken resolves to one index (GHR_W forced equal by re-seeding history).
  - Counter holds at 3.
  - One not-taken resolve gives 2, still predicting 1.
- Same-cycle hazard: fetch and resolve-taken to the same idx with counter=01.
  - `take_flag`=0 that cycle, 1 the next cycle.
- Statistics: 10 resolves, 3 with `i_resolve_mispred`=1, plus 2 cycles of mispred without valid.
  - `o_branch_cnt`=10, `o_miss_cnt`=3.
- Mid-operation reset: pulse `rst` during RUN after training.
  - Outputs return to reset values.
  - INIT reruns for 256 cycles.
  - The previously trained PC predicts 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Gshare branch predictor: 2-bit saturating counters indexed by fetch PC XOR global history.
// A post-reset sweep initialises every counter before predictions and training are enabled.
module branch_predictor #(
   parameter int         IDX_W       = 8,
   parameter int         GHR_W       = 8,
   parameter logic [1:0] INIT_CNT    = 2'b01,
   parameter int         CRAM_ADDR_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CRAM_ADDR_W-1:0] i_fetch_pc,
   output logic                   take_flag,
   input  logic                   i_resolve_valid,
   input  logic [CRAM_ADDR_W-1:0] i_resolve_pc,
   input  logic                   i_resolve_taken,
   input  logic                   i_resolve_mispred,
   output logic                   o_busy,
   output logic [31:0]            o_branch_cnt,
   output logic [31:0]            o_miss_cnt
);

   localparam int DEPTH = 2**IDX_W;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_init_ptr;
   logic [GHR_W-1:0] r_ghr;
   logic [31:0]      r_branch_cnt;
   logic [31:0]      r_miss_cnt;
   logic [1:0]       r_table [DEPTH];

   logic [IDX_W-1:0] w_ghr_ext;
   logic [IDX_W-1:0] w_fetch_idx;
   logic [IDX_W-1:0] w_res_idx;
   logic [1:0]       w_res_cnt;
   logic [1:0]       w_res_next;
   logic             w_upd;
   logic             w_we;
   logic [IDX_W-1:0] w_waddr;
   logic [1:0]       w_wdata;
   logic             w_unused;

   assign w_ghr_ext   = IDX_W'(r_ghr);
   assign w_fetch_idx = i_fetch_pc[IDX_W+1:2] ^ w_ghr_ext;
   assign w_res_idx   = i_resolve_pc[IDX_W+1:2] ^ w_ghr_ext;
   assign w_res_cnt   = r_table[w_res_idx];

   always_comb begin
      w_res_next = w_res_cnt;
      if (i_resolve_taken) begin
         if (w_res_cnt != 2'd3) w_res_next = w_res_cnt + 2'd1;
      end else begin
         if (w_res_cnt != 2'd0) w_res_next = w_res_cnt - 2'd1;
      end
   end

   // Single write port is shared: the sweep owns it in INIT, resolves own it in RUN.
   assign w_upd   = (r_state == ST_RUN) && i_resolve_valid;
   assign w_we    = (r_state == ST_INIT) || w_upd;
   assign w_waddr = (r_state == ST_INIT) ? r_init_ptr : w_res_idx;
   assign w_wdata = (r_state == ST_INIT) ? INIT_CNT : w_res_next;

   always_ff @(posedge clk) begin
      if (w_we) r_table[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_INIT;
         r_init_ptr   <= '0;
         r_ghr        <= '0;
         r_branch_cnt <= '0;
         r_miss_cnt   <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_init_ptr <= r_init_ptr + 1'b1;
               if (r_init_ptr == IDX_W'(DEPTH - 1)) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (i_resolve_valid) begin
                  r_ghr <= {r_ghr[GHR_W-2:0], i_resolve_taken};
                  if (r_branch_cnt != 32'hFFFF_FFFF) r_branch_cnt <= r_branch_cnt + 32'd1;
                  if (i_resolve_mispred && (r_miss_cnt != 32'hFFFF_FFFF))
                     r_miss_cnt <= r_miss_cnt + 32'd1;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   // Prediction reads the pre-write counter; a same-cycle resolve shows up next cycle.
   assign take_flag    = (r_state == ST_RUN) && r_table[w_fetch_idx][1];
   assign o_busy       = (r_state == ST_INIT);
   assign o_branch_cnt = r_branch_cnt;
   assign o_miss_cnt   = r_miss_cnt;

   assign w_unused = ^{i_fetch_pc[1:0], i_fetch_pc[CRAM_ADDR_W-1:IDX_W+2],
                       i_resolve_pc[1:0], i_resolve_pc[CRAM_ADDR_W-1:IDX_W+2]};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: behavioural gshare model checked every cycle, plus
// directed scenarios with hand-computed expectations and a randomized soak.
module tb_branch_predictor;

   localparam int N = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] fetch_pc;
   logic [15:0] res_pc;
   logic        res_valid;
   logic        res_taken;
   logic        res_mispred;
   logic        take_flag;
   logic        busy;
   logic [31:0] bcnt;
   logic [31:0] mcnt;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk               (clk),
      .rst               (rst),
      .i_fetch_pc        (fetch_pc),
      .take_flag         (take_flag),
      .i_resolve_valid   (res_valid),
      .i_resolve_pc      (res_pc),
      .i_resolve_taken   (res_taken),
      .i_resolve_mispred (res_mispred),
      .o_busy            (busy),
      .o_branch_cnt      (bcnt),
      .o_miss_cnt        (mcnt)
   );

   // Reference model: plain integers, one counter per table slot.
   int     m_tab[N];
   int     m_ghr;
   int     m_init_left;
   longint m_bcnt;
   longint m_mcnt;

   function automatic int m_idx(input logic [15:0] pc);
      return ((int'(pc) >> 2) ^ m_ghr) & (N - 1);
   endfunction

   always @(posedge clk or posedge rst) begin
      int k;
      if (rst) begin
         m_init_left = N;
         m_ghr       = 0;
         m_bcnt      = 0;
         m_mcnt      = 0;
         foreach (m_tab[i]) m_tab[i] = 1;
      end else if (m_init_left > 0) begin
         m_init_left--;
      end else if (res_valid) begin
         k = m_idx(res_pc);
         if (res_taken) m_tab[k] = (m_tab[k] >= 3) ? 3 : m_tab[k] + 1;
         else           m_tab[k] = (m_tab[k] <= 0) ? 0 : m_tab[k] - 1;
         m_ghr = ((m_ghr << 1) | int'(res_taken)) & (N - 1);
         if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
         if (res_mispred && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_take_flag", 32'(take_flag),
             (m_init_left > 0) ? 32'd0 : 32'(m_tab[m_idx(fetch_pc)] >> 1));
         chk("model_busy", 32'(busy), 32'(m_init_left > 0));
         chk("model_branch_cnt", bcnt, 32'(m_bcnt));
         chk("model_miss_cnt", mcnt, 32'(m_mcnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic res(input logic [15:0] pc, input logic taken, input logic misp);
      res_valid   = 1'b1;
      res_pc      = pc;
      res_taken   = taken;
      res_mispred = misp;
      tick();
      res_valid   = 1'b0;
      res_mispred = 1'b0;
   endtask

   // Eight not-taken resolves flush the history back to zero.
   task automatic reseed();
      repeat (8) res(16'h03FC, 1'b0, 1'b0);
   endtask

   task automatic lit(input string name, input logic [15:0] pc, input logic exp);
      fetch_pc = pc;
      @(negedge clk);
      chk(name, 32'(take_flag), 32'(exp));
   endtask

   initial begin
      fetch_pc    = 16'h0040;
      res_valid   = 1'b1;
      res_pc      = 16'h0040;
      res_taken   = 1'b1;
      res_mispred = 1'b1;
      cmp_en      = 1'b1;

      // Reset and init sweep with resolves held active throughout.
      repeat (3) tick();
      chk("reset_busy", 32'(busy), 32'd1);
      chk("reset_take", 32'(take_flag), 32'd0);
      chk("reset_bcnt", bcnt, 32'd0);
      chk("reset_mcnt", mcnt, 32'd0);
      rst = 1'b0;
      repeat (N - 1) tick();
      chk("init_busy_last", 32'(busy), 32'd1);
      tick();
      res_valid   = 1'b0;
      res_mispred = 1'b0;
      chk("init_busy_done", 32'(busy), 32'd0);
      chk("init_bcnt", bcnt, 32'd0);
      lit("init_pred_any", 16'(($urandom_range(0, 16383)) << 2), 1'b0);

      // Training on pc 0x40 (index 0x10 with GHR 0).
      res(16'h0040, 1'b1, 1'b0);
      reseed();
      lit("train_cnt2", 16'h0040, 1'b1);
      res(16'h0040, 1'b1, 1'b0);
      reseed();
      lit("train_cnt3", 16'h0040, 1'b1);
      res(16'h0040, 1'b0, 1'b0);
      lit("train_back2", 16'h0040, 1'b1);
      res(16'h0040, 1'b0, 1'b0);
      lit("train_back1", 16'h0040, 1'b0);

      // Saturation on pc 0x80: five taken must stop at 3, not wrap.
      repeat (5) begin
         res(16'h0080, 1'b1, 1'b0);
         reseed();
      end
      lit("sat_hold", 16'h0080, 1'b1);
      res(16'h0080, 1'b0, 1'b0);
      lit("sat_minus1", 16'h0080, 1'b1);
      res(16'h0080, 1'b0, 1'b0);
      lit("sat_minus2", 16'h0080, 1'b0);

      // Same-cycle fetch and resolve to index 0x30 holding 01.
      tick();
      fetch_pc    = 16'h00C0;
      res_valid   = 1'b1;
      res_pc      = 16'h00C0;
      res_taken   = 1'b1;
      res_mispred = 1'b0;
      @(negedge clk);
      chk("hazard_same_cycle", 32'(take_flag), 32'd0);
      tick();
      res_valid = 1'b0;
      lit("hazard_next_cycle", 16'h00C4, 1'b1);

      // Mid-operation reset.
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd1);
      chk("midrst_take", 32'(take_flag), 32'd0);
      chk("midrst_bcnt", bcnt, 32'd0);
      chk("midrst_mcnt", mcnt, 32'd0);
      tick();
      rst = 1'b0;
      repeat (N - 1) tick();
      chk("midrst_busy_last", 32'(busy), 32'd1);
      tick();
      chk("midrst_busy_done", 32'(busy), 32'd0);
      lit("midrst_trained_pc", 16'h00C0, 1'b0);
      lit("midrst_trained_pc2", 16'h0040, 1'b0);

      // Statistics from a clean reset.
      tick();
      for (int i = 0; i < 10; i++)
         res(16'($urandom), 1'($urandom_range(0, 1)), (i < 3) ? 1'b1 : 1'b0);
      res_valid   = 1'b0;
      res_mispred = 1'b1;
      repeat (2) tick();
      res_mispred = 1'b0;
      chk("stats_branch_cnt", bcnt, 32'd10);
      chk("stats_miss_cnt", mcnt, 32'd3);

      // Randomized soak with rare reset pulses.
      repeat (4000) begin
         fetch_pc    = 16'($urandom);
         res_valid   = 1'($urandom_range(0, 1));
         res_pc      = ($urandom_range(0, 3) == 0) ? 16'h0040 : 16'($urandom);
         res_taken   = 1'($urandom_range(0, 1));
         res_mispred = 1'($urandom_range(0, 1));
         rst         = ($urandom_range(0, 1499) == 0);
         tick();
      end
      rst       = 1'b0;
      res_valid = 1'b0;
      tick();

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
